// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, sequencer states and
// instruction field positions.
package alu_pkg;

    // Opcodes, instruction bits [15:12]
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_INC  = 4'h5;
    localparam logic [3:0] OP_DEC  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_LDI  = 4'hB;
    localparam logic [3:0] OP_MOV  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_BRZ  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StHalt
    } seq_state_e;

    // Instruction field slice positions
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 10;
    localparam int unsigned RS_MSB  = 9;
    localparam int unsigned RS_LSB  = 8;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    // Opcodes whose operand 1 is the immediate field rather than a register.
    function automatic logic uses_imm(input logic [3:0] opc);
        return (opc == OP_LDI) || (opc == OP_JMP) || (opc == OP_BRZ);
    endfunction

endpackage

// File: rtl/regfile_4x8.sv
// 4 x 8-bit register file.
//   clk, reset            : rising-edge clock, synchronous active-high reset (regs to 0)
//   ra_addr_i/ra_data_o   : async read port A
//   rb_addr_i/rb_data_o   : async read port B
//   dbg_sel_i/dbg_data_o  : async debug read port
//   we0_i/waddr0_i/wdata0_i : main write port
//   we1_i/waddr1_i/wdata1_i : second write port (MUL high byte)
module regfile_4x8 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ra_addr_i,
    output logic [7:0] ra_data_o,
    input  logic [1:0] rb_addr_i,
    output logic [7:0] rb_data_o,
    input  logic [1:0] dbg_sel_i,
    output logic [7:0] dbg_data_o,
    input  logic       we0_i,
    input  logic [1:0] waddr0_i,
    input  logic [7:0] wdata0_i,
    input  logic       we1_i,
    input  logic [1:0] waddr1_i,
    input  logic [7:0] wdata1_i
);

    logic [7:0] regs_q [4];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (we0_i) begin
                regs_q[waddr0_i] <= wdata0_i;
            end
            // The two write addresses never collide (rd vs rd^1).
            if (we1_i) begin
                regs_q[waddr1_i] <= wdata1_i;
            end
        end
    end

    assign ra_data_o  = regs_q[ra_addr_i];
    assign rb_data_o  = regs_q[rb_addr_i];
    assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller driving an external 8-bit ALU.
// One instruction every three cycles (FETCH, DECODE, EXECUTE).
//   clk, reset             : rising-edge clock, synchronous active-high reset
//   run                    : level, leaves IDLE while high
//   imem_addr / imem_data  : instruction ROM address (= pc) and combinational data
//   alu_opcode/op1/op2     : registered ALU inputs, set in DECODE, held otherwise
//   alu_enable             : high during EXECUTE (except DIV by zero and HALT)
//   alu_out / alu_outmd    : ALU 8-bit and 16-bit mul/div results
//   busy                   : high in FETCH, DECODE, EXECUTE
//   halted / div_err       : sticky status flags
//   dbg_sel / dbg_data     : combinational register-file debug read
module alu_sequencer
    import alu_pkg::*;
#(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter int unsigned IW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    output logic [7:0]    imem_addr,
    input  logic [IW-1:0] imem_data,
    output logic [3:0]    alu_opcode,
    output logic [7:0]    alu_op1,
    output logic [7:0]    alu_op2,
    output logic          alu_enable,
    input  logic [7:0]    alu_out,
    input  logic [15:0]   alu_outmd,
    output logic          busy,
    output logic          halted,
    output logic          div_err,
    input  logic [1:0]    dbg_sel,
    output logic [7:0]    dbg_data
);

    seq_state_e    state_q, state_d;
    logic [7:0]    pc_q, pc_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [3:0]    opcode_q, opcode_d;
    logic [7:0]    op1_q, op1_d;
    logic [7:0]    op2_q, op2_d;
    logic          halted_q, halted_d;
    logic          div_err_q, div_err_d;

    logic [3:0] opc;
    logic [1:0] rd, rs;
    logic [7:0] imm;
    logic [7:0] rd_data, rs_data;

    logic       we0, we1;
    logic [1:0] waddr0, waddr1;
    logic [7:0] wdata0, wdata1;

    assign opc = instr_q[OPC_MSB:OPC_LSB];
    assign rd  = instr_q[RD_MSB:RD_LSB];
    assign rs  = instr_q[RS_MSB:RS_LSB];
    assign imm = instr_q[IMM_MSB:IMM_LSB];

    regfile_4x8 u_regfile (
        .clk        (clk),
        .reset      (reset),
        .ra_addr_i  (rd),
        .ra_data_o  (rd_data),
        .rb_addr_i  (rs),
        .rb_data_o  (rs_data),
        .dbg_sel_i  (dbg_sel),
        .dbg_data_o (dbg_data),
        .we0_i      (we0),
        .waddr0_i   (waddr0),
        .wdata0_i   (wdata0),
        .we1_i      (we1),
        .waddr1_i   (waddr1),
        .wdata1_i   (wdata1)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        opcode_d   = opcode_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        halted_d   = halted_q;
        div_err_d  = div_err_q;
        alu_enable = 1'b0;
        we0        = 1'b0;
        waddr0     = rd;
        wdata0     = alu_out;
        we1        = 1'b0;
        waddr1     = rd ^ 2'b01;
        wdata1     = alu_outmd[15:8];

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                instr_d = imem_data;
                state_d = StDecode;
            end
            StDecode: begin
                opcode_d = opc;
                op2_d    = rs_data;
                if (uses_imm(opc)) begin
                    op1_d = imm;
                end else if (opc == OP_MOV) begin
                    op1_d = rs_data;
                end else begin
                    op1_d = rd_data;
                end
                state_d = StExecute;
            end
            StExecute: begin
                alu_enable = 1'b1;
                pc_d       = pc_q + 8'd1;
                state_d    = run ? StFetch : StIdle;
                case (opcode_q)
                    OP_NOP: ;
                    OP_MUL: begin
                        we0    = 1'b1;
                        wdata0 = alu_outmd[7:0];
                        we1    = 1'b1;
                    end
                    OP_DIV: begin
                        we0 = 1'b1;
                        // Divide-by-zero never reaches the ALU; the result is forced.
                        if (rs_data == 8'h00) begin
                            alu_enable = 1'b0;
                            wdata0     = 8'hFF;
                            div_err_d  = 1'b1;
                        end else begin
                            wdata0 = alu_outmd[7:0];
                        end
                    end
                    OP_JMP: begin
                        pc_d = alu_out;
                    end
                    OP_BRZ: begin
                        if (rd_data == 8'h00) begin
                            pc_d = alu_out;
                        end
                    end
                    OP_HALT: begin
                        alu_enable = 1'b0;
                        halted_d   = 1'b1;
                        pc_d       = pc_q;
                        state_d    = StHalt;
                    end
                    default: begin
                        we0 = 1'b1;
                    end
                endcase
            end
            StHalt: ;
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            opcode_q  <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            halted_q  <= 1'b0;
            div_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            opcode_q  <= opcode_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            halted_q  <= halted_d;
            div_err_q <= div_err_d;
        end
    end

    assign imem_addr  = pc_q;
    assign alu_opcode = opcode_q;
    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign busy       = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExecute);
    assign halted     = halted_q;
    assign div_err    = div_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: instruction-level reference model,
// behavioural ALU, directed programs and randomized ROM/run/reset stimulus.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_op1, alu_op2;
    logic        alu_enable;
    logic [7:0]  alu_out;
    logic [15:0] alu_outmd;
    logic        busy, halted, div_err;
    logic [1:0]  dbg_sel = 2'd0;
    logic [7:0]  dbg_data;

    always #5 clk = ~clk;

    logic [15:0] rom [256];
    assign imem_data = rom[imem_addr];

    alu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .alu_opcode (alu_opcode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_enable (alu_enable),
        .alu_out    (alu_out),
        .alu_outmd  (alu_outmd),
        .busy       (busy),
        .halted     (halted),
        .div_err    (div_err),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    // Behavioural ALU; drives noise whenever it is not enabled.
    logic [7:0]  junk8 = 8'h5A;
    logic [15:0] junk16 = 16'hA5C3;
    always @(negedge clk) begin
        junk8  <= 8'($urandom);
        junk16 <= 16'($urandom);
    end

    always_comb begin
        alu_out   = junk8;
        alu_outmd = junk16;
        if (alu_enable) begin
            case (alu_opcode)
                OP_ADD: alu_out = alu_op1 + alu_op2;
                OP_SUB: alu_out = alu_op1 - alu_op2;
                OP_MUL: alu_outmd = {8'h00, alu_op1} * {8'h00, alu_op2};
                OP_DIV: if (alu_op2 != 8'h00) alu_outmd = {alu_op1 % alu_op2, alu_op1 / alu_op2};
                OP_INC: alu_out = alu_op1 + 8'd1;
                OP_DEC: alu_out = alu_op1 - 8'd1;
                OP_AND: alu_out = alu_op1 & alu_op2;
                OP_OR:  alu_out = alu_op1 | alu_op2;
                OP_NOT: alu_out = ~alu_op1;
                OP_XOR: alu_out = alu_op1 ^ alu_op2;
                OP_LDI, OP_MOV, OP_JMP, OP_BRZ: alu_out = alu_op1;
                default: ;
            endcase
        end
    end

    // Reference model: phase 0 idle, 1 fetch, 2 decode, 3 execute, 4 halted.
    int          phase = 0;
    bit          m_valid = 1'b0;
    logic [7:0]  m_pc = 8'h00;
    logic [7:0]  m_r [4];
    logic [15:0] m_ins = 16'h0000;
    bit          m_halted = 1'b0;
    bit          m_derr = 1'b0;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    bit run_cmd = 1'b0;
    bit rst_cmd = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic model_execute();
        logic [3:0]  op;
        logic [1:0]  rd, rs;
        logic [7:0]  imm, a, b, nxt;
        logic [15:0] p;
        op  = m_ins[15:12];
        rd  = m_ins[11:10];
        rs  = m_ins[9:8];
        imm = m_ins[7:0];
        a   = m_r[rd];
        b   = m_r[rs];
        nxt = m_pc + 8'd1;
        case (op)
            OP_ADD: m_r[rd] = a + b;
            OP_SUB: m_r[rd] = a - b;
            OP_MUL: begin
                p = {8'h00, a} * {8'h00, b};
                m_r[rd] = p[7:0];
                m_r[rd ^ 2'b01] = p[15:8];
            end
            OP_DIV: begin
                if (b == 8'h00) begin
                    m_r[rd] = 8'hFF;
                    m_derr  = 1'b1;
                end else begin
                    m_r[rd] = a / b;
                end
            end
            OP_INC: m_r[rd] = a + 8'd1;
            OP_DEC: m_r[rd] = a - 8'd1;
            OP_AND: m_r[rd] = a & b;
            OP_OR:  m_r[rd] = a | b;
            OP_NOT: m_r[rd] = ~a;
            OP_XOR: m_r[rd] = a ^ b;
            OP_LDI: m_r[rd] = imm;
            OP_MOV: m_r[rd] = b;
            OP_JMP: nxt = imm;
            OP_BRZ: if (a == 8'h00) nxt = imm;
            OP_HALT: begin
                m_halted = 1'b1;
                nxt = m_pc;
            end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic model_update();
        if (reset) begin
            phase    = 0;
            m_pc     = 8'h00;
            m_r      = '{default: 8'h00};
            m_halted = 1'b0;
            m_derr   = 1'b0;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            case (phase)
                0: if (run) phase = 1;
                1: begin
                    m_ins = rom[m_pc];
                    phase = 2;
                end
                2: phase = 3;
                3: begin
                    model_execute();
                    if (m_ins[15:12] == OP_HALT) phase = 4;
                    else phase = run ? 1 : 0;
                end
                default: ;
            endcase
        end
    endtask

    // One clock: compare at the falling edge, drive inputs, advance model at the rising edge.
    task automatic step();
        logic [3:0] op;
        logic [7:0] e_op1;
        bit         e_en;
        @(negedge clk);
        cyc++;
        if (m_valid) begin
            op = m_ins[15:12];
            chk("imem_addr", 32'(imem_addr), 32'(m_pc));
            chk("busy", 32'(busy), 32'(phase >= 1 && phase <= 3));
            chk("halted", 32'(halted), 32'(m_halted));
            chk("div_err", 32'(div_err), 32'(m_derr));
            chk("dbg_data", 32'(dbg_data), 32'(m_r[dbg_sel]));
            e_en = (phase == 3) && (op != OP_HALT) &&
                   !((op == OP_DIV) && (m_r[m_ins[9:8]] == 8'h00));
            chk("alu_enable", 32'(alu_enable), 32'(e_en));
            if (phase == 3) begin
                if (op == OP_LDI || op == OP_JMP || op == OP_BRZ) e_op1 = m_ins[7:0];
                else if (op == OP_MOV) e_op1 = m_r[m_ins[9:8]];
                else e_op1 = m_r[m_ins[11:10]];
                chk("alu_opcode", 32'(alu_opcode), 32'(op));
                chk("alu_op1", 32'(alu_op1), 32'(e_op1));
                chk("alu_op2", 32'(alu_op2), 32'(m_r[m_ins[9:8]]));
            end
        end
        run     = run_cmd;
        reset   = rst_cmd;
        dbg_sel = 2'($urandom);
        @(posedge clk);
        model_update();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic load_and_reset();
        rst_cmd = 1'b1;
        run_cmd = 1'b0;
        step();
        step();
        rst_cmd = 1'b0;
    endtask

    task automatic run_prog(input int max_cycles);
        run_cmd = 1'b1;
        for (int i = 0; i < max_cycles && !m_halted; i++) step();
        step();
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    initial begin
        // Test 1: LDI/LDI/ADD/HALT
        clear_rom();
        rom[0] = enc(OP_LDI, 2'd0, 2'd0, 8'd5);
        rom[1] = enc(OP_LDI, 2'd1, 2'd0, 8'd3);
        rom[2] = enc(OP_ADD, 2'd0, 2'd1, 8'd0);
        rom[3] = enc(OP_HALT, 2'd0, 2'd0, 8'd0);
        load_and_reset();
        chk("reset_pc", 32'(imem_addr), 32'h00);
        run_prog(60);
        chk("t1_r0", 32'(m_r[0]), 32'd8);
        chk("t1_r1", 32'(m_r[1]), 32'd3);
        chk("t1_pc", 32'(m_pc), 32'd3);
        run_cmd = 1'b0;
        repeat (4) step();
        run_cmd = 1'b1;
        repeat (4) step();

        // Test 2: MUL high/low byte split
        clear_rom();
        rom[0] = enc(OP_LDI, 2'd2, 2'd0, 8'h10);
        rom[1] = enc(OP_LDI, 2'd3, 2'd0, 8'h20);
        rom[2] = enc(OP_MUL, 2'd2, 2'd3, 8'h00);
        rom[3] = enc(OP_HALT, 2'd0, 2'd0, 8'h00);
        load_and_reset();
        run_prog(60);
        chk("t2_r2", 32'(m_r[2]), 32'h00);
        chk("t2_r3", 32'(m_r[3]), 32'h02);

        // Test 3: divide by zero, then HALT
        clear_rom();
        rom[0] = enc(OP_LDI, 2'd0, 2'd0, 8'd7);
        rom[1] = enc(OP_LDI, 2'd1, 2'd0, 8'd0);
        rom[2] = enc(OP_DIV, 2'd0, 2'd1, 8'd0);
        rom[3] = enc(OP_HALT, 2'd0, 2'd0, 8'd0);
        load_and_reset();
        run_prog(60);
        chk("t3_r0", 32'(m_r[0]), 32'hFF);
        chk("t3_derr", 32'(m_derr), 32'd1);

        // Test 4a/4b: BRZ taken and not taken
        clear_rom();
        rom[0]    = enc(OP_LDI, 2'd1, 2'd0, 8'd0);
        rom[1]    = enc(OP_BRZ, 2'd1, 2'd0, 8'h20);
        rom[2]    = enc(OP_HALT, 2'd0, 2'd0, 8'd0);
        rom[8'h20] = enc(OP_HALT, 2'd0, 2'd0, 8'd0);
        load_and_reset();
        run_prog(60);
        chk("t4_brz_taken_pc", 32'(m_pc), 32'h20);
        rom[0] = enc(OP_LDI, 2'd1, 2'd0, 8'd1);
        load_and_reset();
        run_prog(60);
        chk("t4_brz_not_taken_pc", 32'(m_pc), 32'h02);

        // Test 4c: JMP 0xFF then NOP at 0xFF wraps pc to 0
        clear_rom();
        rom[0]     = enc(OP_JMP, 2'd0, 2'd0, 8'hFF);
        rom[8'hFF] = enc(OP_NOP, 2'd0, 2'd0, 8'h00);
        load_and_reset();
        run_cmd = 1'b1;
        repeat (7) step();
        chk("t4_wrap_pc", 32'(m_pc), 32'h00);
        run_cmd = 1'b0;
        repeat (4) step();

        // Test 5: INC/DEC wrap
        clear_rom();
        rom[0] = enc(OP_LDI, 2'd0, 2'd0, 8'hFF);
        rom[1] = enc(OP_INC, 2'd0, 2'd0, 8'h00);
        rom[2] = enc(OP_MOV, 2'd1, 2'd0, 8'h00);
        rom[3] = enc(OP_DEC, 2'd0, 2'd0, 8'h00);
        rom[4] = enc(OP_HALT, 2'd0, 2'd0, 8'h00);
        load_and_reset();
        run_prog(60);
        chk("t5_inc_wrap", 32'(m_r[1]), 32'h00);
        chk("t5_dec_wrap", 32'(m_r[0]), 32'hFF);

        // Test 6a: reset during EXECUTE of ADD
        clear_rom();
        rom[0] = enc(OP_LDI, 2'd0, 2'd0, 8'd5);
        rom[1] = enc(OP_LDI, 2'd1, 2'd0, 8'd3);
        rom[2] = enc(OP_ADD, 2'd2, 2'd1, 8'd0);
        rom[3] = enc(OP_HALT, 2'd0, 2'd0, 8'd0);
        load_and_reset();
        run_cmd = 1'b1;
        repeat (9) step();
        chk("t6_in_execute", 32'(phase), 32'd3);
        rst_cmd = 1'b1;
        step();
        rst_cmd = 1'b0;
        run_cmd = 1'b0;
        step();
        chk("t6_r2", 32'(m_r[2]), 32'h00);
        chk("t6_pc", 32'(m_pc), 32'h00);
        repeat (2) step();

        // Test 6b: run drops mid-instruction
        clear_rom();
        rom[0] = enc(OP_LDI, 2'd0, 2'd0, 8'd5);
        rom[1] = enc(OP_LDI, 2'd1, 2'd0, 8'd9);
        rom[2] = enc(OP_HALT, 2'd0, 2'd0, 8'd0);
        load_and_reset();
        run_cmd = 1'b1;
        repeat (2) step();
        run_cmd = 1'b0;
        repeat (5) step();
        chk("t6b_r0", 32'(m_r[0]), 32'd5);
        chk("t6b_r1", 32'(m_r[1]), 32'd0);
        chk("t6b_pc", 32'(m_pc), 32'd1);
        chk("t6b_idle", 32'(phase), 32'd0);

        // Randomized programs, run and reset
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 256; i++) begin
                logic [3:0] op;
                op = 4'($urandom_range(0, 15));
                if (op == OP_HALT && $urandom_range(0, 19) != 0) op = OP_NOP;
                rom[i] = {op, 12'($urandom)};
            end
            load_and_reset();
            for (int c = 0; c < 2000; c++) begin
                run_cmd = ($urandom_range(0, 9) != 0);
                rst_cmd = ($urandom_range(0, 299) == 0);
                step();
            end
            rst_cmd = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Fetch/decode/execute controller that drives the 8-bit ALU: issues opcode, operands and enable; captures alu_out/alu_outmd into a 4x8 register file; updates the program counter.
- Sits between the instruction ROM and the ALU.
- Executes one instruction per 3 cycles: FETCH, DECODE, EXECUTE.

Parameters:
- RESET_PC, 8'h00, PC value after reset.
- IW, 16, instruction width. Fixed format: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- run  in  1  level; sequencer leaves IDLE while high
- imem_addr  out  8  instruction address (= pc)
- imem_data  in  16  instruction; combinational ROM, valid in the same cycle as imem_addr
- alu_opcode  out  4  ALU opcode
- alu_op1  out  8  ALU operand 1
- alu_op2  out  8  ALU operand 2
- alu_enable  out  1  high only in EXECUTE
- alu_out  in  8  ALU 8-bit result
- alu_outmd  in  16  ALU mul/div result
- busy  out  1  high in FETCH, DECODE, EXECUTE
- halted  out  1  sticky; set by HALT
- div_err  out  1  sticky; set by divide-by-zero
- dbg_sel  in  2  register-file debug select
- dbg_data  out  8  R[dbg_sel], combinational

Behaviour:
- Reset (synchronous, active-high, priority over all): state=IDLE, pc=RESET_PC, R0..R3=0, instr=0, alu_opcode=0, alu_op1=0, alu_op2=0, alu_enable=0, halted=0, div_err=0.
- Reset mid-instruction abandons it: no writeback, no PC update.
- States: IDLE, FETCH, DECODE, EXECUTE, HALT.
- IDLE: advance to FETCH on run=1.
- FETCH: instr<=imem_data; advance to DECODE.
- DECODE: register alu_opcode<=instr[15:12]; set operands per opcode, default op1=R[rd], op2=R[rs]; advance to EXECUTE.
- EXECUTE: alu_enable=1; sample ALU result at the closing clock edge; write back and update PC per opcode.
  - Next state is HALT for opcode 1111.
  - Otherwise FETCH if run=1, else IDLE.
- Opcode actions:
  - 0000 NOP: no writeback.
  - 0001 ADD, 0010 SUB, 0111 AND, 1000 OR, 1010 XOR: R[rd]<=alu_out; wraps mod 256.
  - 0011 MUL: R[rd]<=alu_outmd[7:0]; R[rd^1]<=alu_outmd[15:8]. If rd==rs, both operands are the same value.
  - 0100 DIV: R[rd]<=alu_outmd[7:0].
    - If R[rs]==0: alu_enable stays 0, R[rd]<=8'hFF, div_err<=1.
  - 0101 INC, 0110 DEC: R[rd]<=alu_out; FF->00 and 00->FF wrap.
  - 1001 NOT: R[rd]<=alu_out.
  - 1011 LDI: op1=imm; R[rd]<=alu_out.
  - 1100 MOV: op1=R[rs]; R[rd]<=alu_out.
  - 1101 JMP: op1=imm; pc<=alu_out; no register write.
  - 1110 BRZ: op1=imm; if R[rd]==0 then pc<=alu_out, else pc<=pc+1.
  - 1111 HALT: alu_enable=0; halted<=1; stay in HALT until reset. run is ignored.
- PC is pc+1 for all non-jump opcodes; wraps 8'hFF->8'h00.
- alu_op1/alu_op2/alu_opcode hold their values outside EXECUTE. The ALU output is ignored whenever alu_enable=0.
- run dropping mid-instruction: the current instruction completes, then IDLE.
- dbg_data reads the current register state (pre-write in the write cycle).

Decomposition:
- Shared package alu_pkg:
  - opcode localparams: OP_NOP..OP_HALT, 4'h0..4'hF
  - state encoding
  - instruction field slice positions
- Sub-module regfile_4x8:
  - 2 async read ports plus 1 debug read port
  - 2 write ports (second used only by MUL high byte)
  - synchronous reset to 0

Test Plan:
- Reset, run=1, ROM {LDI R0,5; LDI R1,3; ADD R0,R1; HALT} -> R0=8, R1=3, halted=1 after 12 cycles, pc=3, alu_enable low in HALT.
- LDI R2,0x10; LDI R3,0x20; MUL R2,R3 -> R2=0x00, R3=0x02 (0x0200).
- LDI R0,7; LDI R1,0; DIV R0,R1 -> R0=0xFF, div_err=1, alu_enable never high in that EXECUTE; a following HALT still executes.
- LDI R1,0; BRZ R1,0x20 -> pc=0x20. Repeat with R1=1 -> pc=next sequential. JMP 0xFF followed by NOP at 0xFF -> pc wraps to 0x00.
- LDI R0,0xFF; INC R0 -> R0=0x00. DEC R0 -> R0=0xFF.
- Assert reset during the EXECUTE of ADD -> destination unchanged (0), pc=RESET_PC, state IDLE next cycle. Deassert run mid-instruction -> instruction completes, busy=0 after.
